// File: rtl/ov7670_stream_gen_if.sv
// DVP pixel bus between a camera source (or the synthetic generator) and the capture logic.
// All three signals are valid in the consumer's pclk domain, which is the generator's clk.
//   vsync : frame sync, active high
//   href  : high while d carries active pixel bytes
//   d     : pixel byte, two bytes per RGB444 pixel
// Modports: master drives the bus (source side), slave observes it (capture side).
interface ov7670_stream_gen_if;
    logic       vsync;
    logic       href;
    logic [7:0] d;

    modport master (
        output vsync,
        output href,
        output d
    );

    modport slave (
        input vsync,
        input href,
        input d
    );
endinterface

// File: rtl/ov7670_stream_gen.sv
// Synthetic OV7670 source producing the RGB444 vsync/href/byte stream of a real sensor, so the
// capture and processing chain can run without a camera. One clk cycle carries one PCLK byte.
//
// Ports:
//   clk         : byte clock, doubles as the consumer's pclk
//   rst_n       : asynchronous active-low reset
//   enable      : run request, sampled in IDLE and on the last cycle of each frame
//   pattern_sel : 0 SOLID, 1 BARS, 2 ZEBRA, 3 RAMP (latched on frame start)
//   solid_rgb   : RGB444 colour for SOLID (latched on frame start)
//   dvp         : DVP bus (vsync, href, d), master side
//   busy        : high from frame start through the frame_done cycle
//   frame_done  : one-cycle pulse on the last cycle of a frame
//   frame_cnt   : completed frames, wraps
//
// Structure: the FSM and position counters describe the current frame cycle; every output is
// registered from them, so the visible stream trails the FSM by exactly one cycle. This gives
// the two-edge start latency and keeps all relative frame timing intact.
// All vertical phase lengths and STRIPE_H are assumed to be at least 1.
module ov7670_stream_gen #(
    parameter int unsigned IMG_WIDTH   = 320,
    parameter int unsigned IMG_HEIGHT  = 240,
    parameter int unsigned H_BLANK     = 144,
    parameter int unsigned VSYNC_LINES = 3,
    parameter int unsigned V_BACK      = 17,
    parameter int unsigned V_FRONT     = 10,
    parameter int unsigned STRIPE_H    = 16,
    parameter int unsigned ZEBRA_TOP   = 120
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic [1:0]                 pattern_sel,
    input  logic [11:0]                solid_rgb,
    ov7670_stream_gen_if.master        dvp,
    output logic                       busy,
    output logic                       frame_done,
    output logic [15:0]                frame_cnt
);

    localparam int unsigned ACT_BYTES = 2 * IMG_WIDTH;
    localparam int unsigned LINE_LEN  = ACT_BYTES + H_BLANK;
    localparam int unsigned BAR_W     = IMG_WIDTH / 8;

    // With fewer than 8 pixels no bar fits, so every pixel falls in the trailing black area.
    localparam logic [3:0]  BAR_START  = (BAR_W == 0) ? 4'd8 : 4'd0;
    localparam logic [15:0] BAR_W_LAST = (BAR_W == 0) ? 16'd0 : 16'(BAR_W - 1);

    typedef enum logic [2:0] {
        StIdle,
        StVsync,
        StVback,
        StActive,
        StVfront
    } state_e;

    state_e      state_q;
    logic [15:0] col_q;         // byte cycle within the line, 0 .. LINE_LEN-1
    logic [15:0] line_q;        // line within the current vertical phase
    logic [15:0] y_q;           // active line index
    logic [15:0] bar_px_q;      // pixel within the current bar
    logic [3:0]  bar_idx_q;     // current bar, 8 = past the last full bar
    logic [15:0] stripe_cnt_q;  // line within the current zebra stripe
    logic        stripe_odd_q;
    logic        zebra_q;       // current line is at or below ZEBRA_TOP
    logic [1:0]  pat_q;
    logic [11:0] solid_q;

    logic        line_end;
    logic        last_line;
    logic        frame_last;
    logic        in_href;
    logic [11:0] bar_rgb;
    logic [11:0] pix_rgb;
    logic [7:0]  pix_byte;

    always_comb begin
        line_end = (col_q == 16'(LINE_LEN - 1));

        last_line = 1'b0;
        case (state_q)
            StVsync:  last_line = (line_q == 16'(VSYNC_LINES - 1));
            StVback:  last_line = (line_q == 16'(V_BACK - 1));
            StActive: last_line = (line_q == 16'(IMG_HEIGHT - 1));
            StVfront: last_line = (line_q == 16'(V_FRONT - 1));
            default:  last_line = 1'b0;
        endcase

        frame_last = (state_q == StVfront) && last_line && line_end;
        in_href    = (state_q == StActive) && (col_q < 16'(ACT_BYTES));
    end

    always_comb begin
        bar_rgb = 12'h000;
        case (bar_idx_q)
            4'd0:    bar_rgb = 12'hFFF;
            4'd1:    bar_rgb = 12'hFF0;
            4'd2:    bar_rgb = 12'h0FF;
            4'd3:    bar_rgb = 12'h0F0;
            4'd4:    bar_rgb = 12'hF0F;
            4'd5:    bar_rgb = 12'hF00;
            4'd6:    bar_rgb = 12'h00F;
            default: bar_rgb = 12'h000;
        endcase

        pix_rgb = 12'h000;
        unique case (pat_q)
            2'd0:    pix_rgb = solid_q;
            2'd1:    pix_rgb = bar_rgb;
            2'd2:    pix_rgb = zebra_q ? (stripe_odd_q ? 12'h000 : 12'hFFF) : 12'h444;
            // x is col/2, so col[4:1] is x[3:0]
            default: pix_rgb = {col_q[4:1], y_q[3:0], frame_cnt[3:0]};
        endcase

        pix_byte = col_q[0] ? pix_rgb[7:0] : {4'h0, pix_rgb[11:8]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            col_q        <= 16'd0;
            line_q       <= 16'd0;
            y_q          <= 16'd0;
            bar_px_q     <= 16'd0;
            bar_idx_q    <= BAR_START;
            stripe_cnt_q <= 16'd0;
            stripe_odd_q <= 1'b0;
            zebra_q      <= 1'b0;
            pat_q        <= 2'd0;
            solid_q      <= 12'h000;
            dvp.vsync    <= 1'b0;
            dvp.href     <= 1'b0;
            dvp.d        <= 8'h00;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            frame_cnt    <= 16'd0;
        end else begin
            // Registered outputs, one cycle behind the FSM position
            dvp.vsync  <= (state_q == StVsync);
            dvp.href   <= in_href;
            dvp.d      <= in_href ? pix_byte : 8'h00;
            busy       <= (state_q != StIdle);
            frame_done <= frame_last;
            if (frame_last) begin
                frame_cnt <= frame_cnt + 16'd1;
            end

            // Horizontal / vertical position
            if (state_q != StIdle) begin
                if (line_end) begin
                    col_q  <= 16'd0;
                    line_q <= last_line ? 16'd0 : line_q + 16'd1;
                end else begin
                    col_q <= col_q + 16'd1;
                end
            end

            // Bar tracking advances after the second byte of each pixel
            if (line_end) begin
                bar_px_q  <= 16'd0;
                bar_idx_q <= BAR_START;
            end else if (in_href && col_q[0] && (bar_idx_q != 4'd8)) begin
                if (bar_px_q == BAR_W_LAST) begin
                    bar_px_q  <= 16'd0;
                    bar_idx_q <= bar_idx_q + 4'd1;
                end else begin
                    bar_px_q <= bar_px_q + 16'd1;
                end
            end

            // Active-line and zebra stripe tracking, updated at line boundaries
            if ((state_q == StVback) && last_line && line_end) begin
                y_q          <= 16'd0;
                zebra_q      <= (ZEBRA_TOP == 0);
                stripe_cnt_q <= 16'd0;
                stripe_odd_q <= 1'b0;
            end else if ((state_q == StActive) && line_end) begin
                y_q <= y_q + 16'd1;
                if ((y_q + 16'd1) == 16'(ZEBRA_TOP)) begin
                    zebra_q      <= 1'b1;
                    stripe_cnt_q <= 16'd0;
                    stripe_odd_q <= 1'b0;
                end else if (zebra_q) begin
                    if (stripe_cnt_q == 16'(STRIPE_H - 1)) begin
                        stripe_cnt_q <= 16'd0;
                        stripe_odd_q <= ~stripe_odd_q;
                    end else begin
                        stripe_cnt_q <= stripe_cnt_q + 16'd1;
                    end
                end
            end

            // Frame sequencing; pattern inputs are captured only on frame start
            case (state_q)
                StIdle: begin
                    if (enable) begin
                        state_q <= StVsync;
                        col_q   <= 16'd0;
                        line_q  <= 16'd0;
                        pat_q   <= pattern_sel;
                        solid_q <= solid_rgb;
                    end
                end
                StVsync: begin
                    if (line_end && last_line) begin
                        state_q <= StVback;
                    end
                end
                StVback: begin
                    if (line_end && last_line) begin
                        state_q <= StActive;
                    end
                end
                StActive: begin
                    if (line_end && last_line) begin
                        state_q <= StVfront;
                    end
                end
                StVfront: begin
                    if (line_end && last_line) begin
                        if (enable) begin
                            state_q <= StVsync;
                            pat_q   <= pattern_sel;
                            solid_q <= solid_rgb;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ov7670_stream_gen.sv
// Directed bench for ov7670_stream_gen with a small geometry (8x4 image, L=20, 140-cycle frame).
// Each frame is captured cycle by cycle as {vsync, href, frame_done, busy, d} and compared with
// expected vectors derived from the frame geometry and hand-written pattern byte tables.
module tb_ov7670_stream_gen;

    localparam int L     = 20;
    localparam int FRAME = 140;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [1:0]  pattern_sel;
    logic [11:0] solid_rgb;
    logic        busy;
    logic        frame_done;
    logic [15:0] frame_cnt;

    int checks = 0;
    int errors = 0;

    logic [11:0] cap [FRAME];

    // Line bytes for BARS with 1-pixel bars
    logic [7:0]  bars_line [16] = '{8'h0F, 8'hFF, 8'h0F, 8'hF0, 8'h00, 8'hFF, 8'h00, 8'hF0,
                                    8'h0F, 8'h0F, 8'h0F, 8'h00, 8'h00, 8'h0F, 8'h00, 8'h00};
    // ZEBRA colour per active line with ZEBRA_TOP=2, STRIPE_H=1
    logic [11:0] zebra_rgb [4] = '{12'h444, 12'h444, 12'hFFF, 12'h000};

    ov7670_stream_gen_if dvp ();

    ov7670_stream_gen #(
        .IMG_WIDTH   (8),
        .IMG_HEIGHT  (4),
        .H_BLANK     (4),
        .VSYNC_LINES (1),
        .V_BACK      (1),
        .V_FRONT     (1),
        .STRIPE_H    (1),
        .ZEBRA_TOP   (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .pattern_sel (pattern_sel),
        .solid_rgb   (solid_rgb),
        .dvp         (dvp),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_cnt   (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    // Expected {vsync, href, frame_done, busy, d} at frame cycle c
    function automatic logic [11:0] exp_frame(input int pat, input logic [11:0] rgb,
                                              input logic [3:0] fc, input int c);
        int          line;
        int          col;
        int          y;
        logic        hr;
        logic [11:0] px;
        logic [7:0]  b;
        line = c / L;
        col  = c % L;
        y    = line - 2;
        hr   = (line >= 2) && (line < 6) && (col < 16);
        px   = 12'h000;
        b    = 8'h00;
        if (hr) begin
            case (pat)
                0:       px = rgb;
                2:       px = zebra_rgb[y];
                3:       px = {4'(col / 2), 4'(y), fc};
                default: px = 12'h000;
            endcase
            b = (col % 2 == 1) ? px[7:0] : {4'h0, px[11:8]};
            if (pat == 1) b = bars_line[col];
        end
        return {line == 0, hr, c == FRAME - 1, 1'b1, b};
    endfunction

    // Records the current cycle as frame cycle 0 and the following FRAME-1 cycles.
    task automatic capture_frame(input int drop_at, input logic [1:0] new_pat);
        for (int c = 0; c < FRAME; c++) begin
            if (c > 0) @(negedge clk);
            cap[c] = {dvp.vsync, dvp.href, frame_done, busy, dvp.d};
            if (c == drop_at) begin
                enable      = 1'b0;
                pattern_sel = new_pat;
            end
        end
    endtask

    task automatic start_frame(input logic [1:0] pat, input logic [11:0] rgb);
        int n;
        pattern_sel = pat;
        solid_rgb   = rgb;
        enable      = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (dvp.vsync !== 1'b1 && n < 400);
        checks++;
        if (dvp.vsync !== 1'b1) begin
            errors++;
            $display("FAIL start_timeout: vsync got %b after %0d cycles, required 1", dvp.vsync, n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({dvp.vsync, dvp.href, frame_done, busy, dvp.d, frame_cnt} !== 28'h0) begin
            errors++;
            $display("FAIL reset_values: got vs=%b hr=%b fd=%b busy=%b d=%h cnt=%h, required all 0",
                     dvp.vsync, dvp.href, frame_done, busy, dvp.d, frame_cnt);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if ({dvp.vsync, busy} !== 2'b00) begin
            errors++;
            $display("FAIL idle_wait: got vs=%b busy=%b, required 0 0", dvp.vsync, busy);
        end
    endtask

    task automatic test_solid();
        logic [11:0] e;
        pattern_sel = 2'd0;
        solid_rgb   = 12'hA5C;
        enable      = 1'b1;
        @(negedge clk);
        checks++;
        if ({dvp.vsync, busy} !== 2'b00) begin
            errors++;
            $display("FAIL start_latency_early: got vs=%b busy=%b, required 0 0", dvp.vsync, busy);
        end
        @(negedge clk);
        checks++;
        if ({dvp.vsync, busy} !== 2'b11) begin
            errors++;
            $display("FAIL start_latency: got vs=%b busy=%b, required 1 1", dvp.vsync, busy);
        end
        capture_frame(50, 2'd0);
        for (int c = 0; c < FRAME; c++) begin
            e = exp_frame(0, 12'hA5C, 4'h0, c);
            checks++;
            if (cap[c] !== e) begin
                errors++;
                $display("FAIL solid_frame cycle %0d: got %h required %h", c, cap[c], e);
            end
        end
        @(negedge clk);
        checks++;
        if ({dvp.vsync, busy, frame_cnt} !== {2'b00, 16'd1}) begin
            errors++;
            $display("FAIL solid_end: got vs=%b busy=%b cnt=%0d, required 0 0 1",
                     dvp.vsync, busy, frame_cnt);
        end
        repeat (5) @(negedge clk);
        checks++;
        if ({dvp.vsync, busy} !== 2'b00) begin
            errors++;
            $display("FAIL solid_stays_idle: got vs=%b busy=%b, required 0 0", dvp.vsync, busy);
        end
    endtask

    // Enable drops mid-ACTIVE and pattern_sel changes; the frame must stay BARS.
    task automatic test_bars_enable_drop();
        logic [11:0] e;
        start_frame(2'd1, 12'h000);
        capture_frame(60, 2'd0);
        for (int c = 0; c < FRAME; c++) begin
            e = exp_frame(1, 12'h000, 4'h0, c);
            checks++;
            if (cap[c] !== e) begin
                errors++;
                $display("FAIL bars_frame cycle %0d: got %h required %h", c, cap[c], e);
            end
        end
        @(negedge clk);
        checks++;
        if ({dvp.vsync, busy, frame_cnt} !== {2'b00, 16'd2}) begin
            errors++;
            $display("FAIL bars_end: got vs=%b busy=%b cnt=%0d, required 0 0 2",
                     dvp.vsync, busy, frame_cnt);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (dvp.vsync !== 1'b0) begin
            errors++;
            $display("FAIL bars_no_restart: got vs=%b, required 0", dvp.vsync);
        end
    endtask

    task automatic test_zebra();
        logic [11:0] e;
        start_frame(2'd2, 12'h000);
        capture_frame(50, 2'd2);
        for (int c = 0; c < FRAME; c++) begin
            e = exp_frame(2, 12'h000, 4'h0, c);
            checks++;
            if (cap[c] !== e) begin
                errors++;
                $display("FAIL zebra_frame cycle %0d: got %h required %h", c, cap[c], e);
            end
        end
        @(negedge clk);
        checks++;
        if ({busy, frame_cnt} !== {1'b0, 16'd3}) begin
            errors++;
            $display("FAIL zebra_end: got busy=%b cnt=%0d, required 0 3", busy, frame_cnt);
        end
    endtask

    // Reset at frame cycle 60 (active line 1, first byte of SOLID 123 = 01).
    task automatic test_async_reset();
        start_frame(2'd0, 12'h123);
        repeat (60) @(negedge clk);
        checks++;
        if ({dvp.href, dvp.d} !== {1'b1, 8'h01}) begin
            errors++;
            $display("FAIL pre_reset_byte: got hr=%b d=%h, required 1 01", dvp.href, dvp.d);
        end
        pattern_sel = 2'd3;
        rst_n       = 1'b0;
        #1;
        checks++;
        if ({dvp.vsync, dvp.href, frame_done, busy, dvp.d, frame_cnt} !== 28'h0) begin
            errors++;
            $display("FAIL async_reset: got vs=%b hr=%b fd=%b busy=%b d=%h cnt=%h, required all 0",
                     dvp.vsync, dvp.href, frame_done, busy, dvp.d, frame_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (dvp.vsync !== 1'b0) begin
            errors++;
            $display("FAIL restart_early: got vs=%b, required 0", dvp.vsync);
        end
        @(negedge clk);
        checks++;
        if ({dvp.vsync, busy} !== 2'b11) begin
            errors++;
            $display("FAIL restart: got vs=%b busy=%b, required 1 1", dvp.vsync, busy);
        end
    endtask

    // Continues from the frame restarted by test_async_reset (RAMP, frame_cnt 0).
    task automatic test_back_to_back_ramp();
        logic [11:0] e;
        capture_frame(-1, 2'd3);
        for (int c = 0; c < FRAME; c++) begin
            e = exp_frame(3, 12'h000, 4'h0, c);
            checks++;
            if (cap[c] !== e) begin
                errors++;
                $display("FAIL ramp1_frame cycle %0d: got %h required %h", c, cap[c], e);
            end
        end
        checks++;
        if ({cap[110][7:0], cap[111][7:0]} !== 16'h0530) begin
            errors++;
            $display("FAIL ramp1_pixel: got %h%h, required 0530", cap[110][7:0], cap[111][7:0]);
        end
        @(negedge clk);
        checks++;
        if ({dvp.vsync, busy, frame_cnt} !== {2'b11, 16'd1}) begin
            errors++;
            $display("FAIL back_to_back: got vs=%b busy=%b cnt=%0d, required 1 1 1",
                     dvp.vsync, busy, frame_cnt);
        end
        capture_frame(50, 2'd3);
        for (int c = 0; c < FRAME; c++) begin
            e = exp_frame(3, 12'h000, 4'h1, c);
            checks++;
            if (cap[c] !== e) begin
                errors++;
                $display("FAIL ramp2_frame cycle %0d: got %h required %h", c, cap[c], e);
            end
        end
        checks++;
        if ({cap[110][7:0], cap[111][7:0]} !== 16'h0531) begin
            errors++;
            $display("FAIL ramp2_pixel: got %h%h, required 0531", cap[110][7:0], cap[111][7:0]);
        end
        @(negedge clk);
        checks++;
        if ({busy, frame_cnt} !== {1'b0, 16'd2}) begin
            errors++;
            $display("FAIL ramp_end: got busy=%b cnt=%0d, required 0 2", busy, frame_cnt);
        end
    endtask

    initial begin
        enable      = 1'b0;
        pattern_sel = 2'd0;
        solid_rgb   = 12'h000;
        test_reset();
        test_solid();
        test_bars_enable_drop();
        test_zebra();
        test_async_reset();
        test_back_to_back_ramp();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
